// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU control outputs of imem_loader.
// The master modport belongs to the loader; the slave modport belongs to the stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic [DATA_W-1:0] imem_rdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;
    logic [7:0]        words_loaded;

    modport master (
        input  rx_data, rx_valid, imem_rdata,
        output rx_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, load_done, load_error, words_loaded
    );

    modport slave (
        output rx_data, rx_valid, imem_rdata,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Receives a framed program image (A5, N, N x {HI,LO}, CSUM) and writes 10-bit words into instruction RAM.
// Define IMEM_LOADER_READBACK_EN to verify every written word through imem_rdata before moving on.
module imem_loader #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 10,
    parameter int BASE_ADDR      = 0,
    parameter int MAX_WORDS      = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus
);
    generate
        if (DATA_W != 10) begin : g_bad_data_w
            $error("imem_loader: DATA_W must be 10");
        end
        if (MAX_WORDS < 1 || MAX_WORDS > 255) begin : g_bad_max_words
            $error("imem_loader: MAX_WORDS must be in 1..255");
        end
    endgenerate

    localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        MAX_W8    = 8'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [7:0]        HDR_BYTE  = 8'hA5;

`ifdef IMEM_LOADER_READBACK_EN
    typedef enum logic [3:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR, S_VERIFY
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic              r_rx_ready;
    logic              r_imem_we;
    logic              w_rx_ready_next;
    logic              w_imem_we_next;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [DATA_W-1:0] r_imem_wdata;
    logic              r_cpu_hold;
    logic              r_load_done;
    logic              r_load_error;
    logic [7:0]        r_words_loaded;
    logic [7:0]        r_count;
    logic [7:0]        r_csum;
    logic [1:0]        r_hi;
    logic [TMO_W-1:0]  r_tmo;

    logic w_hs;
    logic w_frame_state;
    logic w_tmo_hit;
    logic w_last_word;
    logic w_word_end;
    logic w_hdr;

    assign w_hs          = bus.rx_valid & r_rx_ready;
    assign w_frame_state = (r_state == S_COUNT) || (r_state == S_HI) ||
                           (r_state == S_LO)    || (r_state == S_CSUM);
    assign w_tmo_hit     = w_frame_state && !w_hs && (r_tmo == TMO_LAST);
    assign w_last_word   = ((r_words_loaded + 8'd1) == r_count);
    // A header is the only way into COUNT from outside it.
    assign w_hdr         = (w_state_next == S_COUNT) && (r_state != S_COUNT);

`ifdef IMEM_LOADER_READBACK_EN
    assign w_word_end = (r_state == S_VERIFY);
`else
    assign w_word_end = (r_state == S_WRITE);
    logic w_unused_rdata;
    assign w_unused_rdata = ^bus.imem_rdata;
`endif

    always_ff @(posedge clk) begin : p_state_reg
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_imem_we  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rx_ready <= w_rx_ready_next;
            r_imem_we  <= w_imem_we_next;
        end
    end

    always_comb begin : p_next_state
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_hs && bus.rx_data == HDR_BYTE) w_state_next = S_COUNT;
            end
            S_ERR: begin
                w_state_next = (w_hs && bus.rx_data == HDR_BYTE) ? S_COUNT : S_IDLE;
            end
            S_COUNT: begin
                if (w_tmo_hit)
                    w_state_next = S_ERR;
                else if (w_hs)
                    w_state_next = (bus.rx_data == 8'd0 || bus.rx_data > MAX_W8) ? S_ERR : S_HI;
            end
            S_HI: begin
                if (w_tmo_hit)
                    w_state_next = S_ERR;
                else if (w_hs)
                    w_state_next = (bus.rx_data[7:2] != 6'd0) ? S_ERR : S_LO;
            end
            S_LO: begin
                if (w_tmo_hit)
                    w_state_next = S_ERR;
                else if (w_hs)
                    w_state_next = S_WRITE;
            end
`ifdef IMEM_LOADER_READBACK_EN
            S_WRITE: w_state_next = S_VERIFY;
            S_VERIFY: begin
                if (bus.imem_rdata != r_imem_wdata)
                    w_state_next = S_ERR;
                else
                    w_state_next = w_last_word ? S_CSUM : S_HI;
            end
`else
            S_WRITE: w_state_next = w_last_word ? S_CSUM : S_HI;
`endif
            S_CSUM: begin
                if (w_tmo_hit)
                    w_state_next = S_ERR;
                else if (w_hs)
                    w_state_next = (bus.rx_data == r_csum) ? S_DONE : S_ERR;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free and independent of rx_valid.
    always_comb begin : p_outputs
        w_rx_ready_next = 1'b1;
        w_imem_we_next  = 1'b0;
        case (w_state_next)
            S_WRITE: begin
                w_rx_ready_next = 1'b0;
                w_imem_we_next  = 1'b1;
            end
`ifdef IMEM_LOADER_READBACK_EN
            S_VERIFY: w_rx_ready_next = 1'b0;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin : p_datapath
        if (!rst) begin
            r_imem_addr    <= BASE;
            r_imem_wdata   <= '0;
            r_cpu_hold     <= 1'b1;
            r_load_done    <= 1'b0;
            r_load_error   <= 1'b0;
            r_words_loaded <= 8'd0;
            r_count        <= 8'd0;
            r_csum         <= 8'd0;
            r_hi           <= 2'd0;
            r_tmo          <= '0;
        end else begin
            if (w_hdr) begin
                r_cpu_hold     <= 1'b1;
                r_load_done    <= 1'b0;
                r_load_error   <= 1'b0;
                r_words_loaded <= 8'd0;
                r_imem_addr    <= BASE;
                r_csum         <= 8'd0;
            end
            if (r_state == S_COUNT && w_state_next == S_HI) begin
                r_count <= bus.rx_data;
                r_csum  <= r_csum ^ bus.rx_data;
            end
            if (r_state == S_HI && w_state_next == S_LO) begin
                r_hi   <= bus.rx_data[1:0];
                r_csum <= r_csum ^ bus.rx_data;
            end
            if (r_state == S_LO && w_state_next == S_WRITE) begin
                r_imem_wdata <= {r_hi, bus.rx_data};
                r_csum       <= r_csum ^ bus.rx_data;
            end
            if (w_word_end) begin
                r_words_loaded <= r_words_loaded + 8'd1;
                r_imem_addr    <= r_imem_addr + ADDR_W'(1);
            end
            if (r_state == S_CSUM && w_state_next == S_DONE) begin
                r_cpu_hold  <= 1'b0;
                r_load_done <= 1'b1;
            end
            if (w_state_next == S_ERR) r_load_error <= 1'b1;
            if (w_frame_state && !w_hs)
                r_tmo <= r_tmo + TMO_W'(1);
            else
                r_tmo <= '0;
        end
    end

    assign bus.rx_ready     = r_rx_ready;
    assign bus.imem_we      = r_imem_we;
    assign bus.imem_addr    = r_imem_addr;
    assign bus.imem_wdata   = r_imem_wdata;
    assign bus.cpu_hold     = r_cpu_hold;
    assign bus.load_done    = r_load_done;
    assign bus.load_error   = r_load_error;
    assign bus.words_loaded = r_words_loaded;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: per-scenario tasks drive byte frames, a scoreboard queue holds
// the expected memory writes and a negedge monitor pops and compares them as imem_we pulses appear.
module tb_imem_loader;
    localparam int ADDR_W         = 10;
    localparam int DATA_W         = 10;
    localparam int BASE_ADDR      = 0;
    localparam int MAX_WORDS      = 128;
    localparam int TIMEOUT_CYCLES = 1024;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR),
        .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Instruction memory model; address 1 can be made to read back corrupted.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    bit corrupt = 1'b0;
    always @(posedge clk) if (bus.imem_we === 1'b1) mem[bus.imem_addr] <= bus.imem_wdata;
    assign bus.imem_rdata = (corrupt && bus.imem_addr == ADDR_W'(1)) ?
                            (mem[bus.imem_addr] ^ DATA_W'(1)) : mem[bus.imem_addr];

    wr_t               exp_q[$];
    wr_t               mon_exp;
    int                tests_run    = 0;
    int                tests_failed = 0;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] wq[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL write_unexpected: got addr=%0h data=%0h, required no write", bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.imem_addr !== mon_exp.addr || bus.imem_wdata !== mon_exp.data) begin
                    tests_failed++;
                    $display("FAIL write_data: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             bus.imem_addr, bus.imem_wdata, mon_exp.addr, mon_exp.data);
                end else begin
                    $display("[TB] write addr=%0h data=%0h ok", bus.imem_addr, bus.imem_wdata);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the handshake with rx_valid dropped.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus.rx_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL rx_ready_wait: byte %02h not accepted after %0d cycles, required rx_ready=1", b, waited);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] words[$], input logic [7:0] csum_xor, input bit chk_hdr);
        logic [7:0] cs;
        logic [7:0] hi;
        logic [7:0] lo;
        send_byte(8'hA5);
        if (chk_hdr) begin
            tests_run++;
            if (bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0 || bus.load_error !== 1'b0 || bus.words_loaded !== 8'd0) begin
                tests_failed++;
                $display("FAIL header_clear: got hold=%b done=%b err=%b words=%0d, required 1 0 0 0",
                         bus.cpu_hold, bus.load_done, bus.load_error, bus.words_loaded);
            end
        end
        exp_addr = ADDR_W'(BASE_ADDR);
        cs = 8'(words.size());
        send_byte(cs);
        foreach (words[i]) begin
            hi = {6'd0, words[i][9:8]};
            lo = words[i][7:0];
            cs = cs ^ hi ^ lo;
            send_byte(hi);
            exp_q.push_back({exp_addr, words[i]});
            exp_addr = exp_addr + ADDR_W'(1);
            send_byte(lo);
            tests_run++;
            if (bus.imem_we !== 1'b1) begin
                tests_failed++;
                $display("FAIL write_latency: word %0d imem_we=%b one cycle after LO, required 1", i, bus.imem_we);
            end
        end
        send_byte(cs ^ csum_xor);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.rx_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: got rx_ready=%b we=%b, required 0 0", bus.rx_ready, bus.imem_we);
        end
        tests_run++;
        if (bus.imem_addr !== ADDR_W'(BASE_ADDR) || bus.imem_wdata !== '0 || bus.words_loaded !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got addr=%0h wdata=%0h words=%0d, required %0h 0 0",
                     bus.imem_addr, bus.imem_wdata, bus.words_loaded, BASE_ADDR);
        end
        tests_run++;
        if (bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0 || bus.load_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got hold=%b done=%b err=%b, required 1 0 0", bus.cpu_hold, bus.load_done, bus.load_error);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.rx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_ready: got rx_ready=%b, required 1", bus.rx_ready);
        end
    endtask

    task automatic check_done(input string name, input logic [7:0] n_words);
        tests_run++;
        if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.load_error !== 1'b0 || bus.words_loaded !== n_words) begin
            tests_failed++;
            $display("FAIL %s: got done=%b hold=%b err=%b words=%0d, required 1 0 0 %0d",
                     name, bus.load_done, bus.cpu_hold, bus.load_error, bus.words_loaded, n_words);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_writes: got %0d writes missing, required 0", name, exp_q.size());
        end
    endtask

    task automatic check_error(input string name);
        tests_run++;
        if (bus.load_error !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got err=%b hold=%b done=%b, required 1 1 0", name, bus.load_error, bus.cpu_hold, bus.load_done);
        end
    endtask

    task automatic test_good_load();
        wq = {};
        wq.push_back(10'h123);
        wq.push_back(10'h07F);
        send_frame(wq, 8'h00, 1'b0);
        check_done("good_load", 8'd2);
        tests_run++;
        if (bus.imem_addr !== ADDR_W'(BASE_ADDR + 2)) begin
            tests_failed++;
            $display("FAIL good_load_addr: got %0h, required %0h", bus.imem_addr, BASE_ADDR + 2);
        end
        send_byte(8'h00);
        tests_run++;
        if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_ignores_byte: got done=%b hold=%b, required 1 0", bus.load_done, bus.cpu_hold);
        end
    endtask

    task automatic test_back_to_back();
        wq = {};
        wq.push_back(10'h3FF);
        wq.push_back(10'h000);
        wq.push_back(10'h2A5);
        send_frame(wq, 8'h00, 1'b1);
        check_done("back_to_back", 8'd3);
    endtask

    task automatic test_bad_csum();
        wq = {};
        wq.push_back(10'h123);
        wq.push_back(10'h07F);
        send_frame(wq, 8'h03, 1'b0);
        check_error("bad_csum");
        tests_run++;
        if (exp_q.size() != 0 || bus.words_loaded !== 8'd2) begin
            tests_failed++;
            $display("FAIL bad_csum_writes: got pending=%0d words=%0d, required 0 2", exp_q.size(), bus.words_loaded);
        end
        repeat (3) @(negedge clk);
        check_error("error_sticky");
        send_frame(wq, 8'h00, 1'b1);
        check_done("recover", 8'd2);
    endtask

    task automatic test_bad_count();
        logic [7:0] counts[2];
        counts[0] = 8'h00;
        counts[1] = 8'(MAX_WORDS + 1);
        for (int k = 0; k < 2; k++) begin
            send_byte(8'hA5);
            send_byte(counts[k]);
            check_error($sformatf("bad_count_%02h", counts[k]));
            send_byte(8'h00);
            send_byte(8'h12);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_max_words();
        wq = {};
        for (int k = 0; k < MAX_WORDS; k++) wq.push_back(DATA_W'($urandom_range(0, 1023)));
        send_frame(wq, 8'h00, 1'b1);
        check_done("max_words", 8'(MAX_WORDS));
    endtask

    task automatic test_bad_hi();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h04);
        check_error("bad_hi");
        send_byte(8'h33);
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.words_loaded !== 8'd0) begin
            tests_failed++;
            $display("FAIL bad_hi_words: got %0d, required 0", bus.words_loaded);
        end
    endtask

    task automatic test_timeout();
        int waited = 0;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
        tests_run++;
        if (bus.load_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_early: got err=%b after %0d idle cycles, required 0", bus.load_error, TIMEOUT_CYCLES - 1);
        end
        while (bus.load_error !== 1'b1 && waited < 3) begin
            @(negedge clk);
            waited++;
        end
        check_error("timeout");
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        exp_q.push_back({ADDR_W'(BASE_ADDR), 10'h123});
        send_byte(8'h23);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.imem_addr !== ADDR_W'(BASE_ADDR) || bus.words_loaded !== 8'd0 || bus.imem_wdata !== '0 ||
            bus.rx_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_reset: got addr=%0h words=%0d wdata=%0h ready=%b we=%b, required %0h 0 0 0 0",
                     bus.imem_addr, bus.words_loaded, bus.imem_wdata, bus.rx_ready, bus.imem_we, BASE_ADDR);
        end
        tests_run++;
        if (bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0 || bus.load_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_flags: got hold=%b done=%b err=%b, required 1 0 0", bus.cpu_hold, bus.load_done, bus.load_error);
        end
        rst = 1'b1;
        @(negedge clk);
        send_byte(8'h00);
        send_byte(8'h7F);
        repeat (2) @(negedge clk);
        wq = {};
        wq.push_back(10'h155);
        wq.push_back(10'h2AA);
        send_frame(wq, 8'h00, 1'b1);
        check_done("after_reset", 8'd2);
    endtask

`ifdef IMEM_LOADER_READBACK_EN
    task automatic test_readback();
        int waited = 0;
        corrupt = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        exp_q.push_back({ADDR_W'(BASE_ADDR), 10'h155});
        send_byte(8'h55);
        @(negedge clk);
        tests_run++;
        if (bus.load_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL readback_word0: got err=%b, required 0", bus.load_error);
        end
        send_byte(8'h02);
        exp_q.push_back({ADDR_W'(BASE_ADDR + 1), 10'h2AA});
        send_byte(8'hAA);
        while (bus.load_error !== 1'b1 && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        check_error("readback");
        corrupt = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_load();
        test_back_to_back();
        test_bad_csum();
        test_bad_count();
        test_max_words();
        test_bad_hi();
        test_timeout();
        test_reset_midframe();
`ifdef IMEM_LOADER_READBACK_EN
        test_readback();
`endif
        repeat (4) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
